logic_gate_unit: RTL and testbench
==================================

Name: logic_gate_unit

Overview:
- Parametrised, registered successor to the 2-input AND `top` in the FPGA template.
- Computes a selectable WIDTH-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR) on a streamed input.
- Has a valid/ready output stage and a built-in truth-table sweep mode that walks all 2^WIDTH input combinations on-chip.
- Sits between board I/O (switches/buttons, already synchronised) and LED/UART reporting logic.

Parameters:
- WIDTH, 2, number of gate inputs; legal range 2..8.
- CNT_W, WIDTH+1, derived (localparam, not overridable); width of sweep counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- op  in  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_valid  in  1  stream input valid.
- in_ready  out  1  stream input ready.
- in_data  in  WIDTH  gate input vector.
- sweep_start  in  1  single-cycle request to start a truth-table sweep.
- sweep_busy  out  1  high while a sweep is in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_vec  out  WIDTH  input vector that produced the result.
- out_c  out  1  gate result.
- out_err  out  1  op was reserved (6/7) for this result; out_c forced 0.
- out_last  out  1  final vector of a sweep; 0 in stream mode.
- sweep_ones  out  CNT_W  count of results equal to 1 in the last completed sweep.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, out_c, out_err, out_last, sweep_busy = 0; out_vec = 0; sweep_ones = 0.
  - FSM = IDLE; vector counter = 0; ones accumulator = 0.
- Output register: single stage.
  - stage_free = !out_valid || out_ready.
  - Loaded on a cycle when stage_free and a source fires.
  - out_valid clears when out_ready=1 and nothing new is loaded.
- Stalls: while out_valid=1 and out_ready=0, out_vec/out_c/out_err/out_last hold stable.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - in_ready = stage_free && !sweep_start.
  - Transfer on in_valid && in_ready: next cycle out_valid=1, out_vec=in_data, out_c=f(op, in_data), out_last=0.
  - Latency: 1 clock from transfer to out_valid.
  - op is sampled per transfer.
- Starting a sweep: sweep_start=1 in IDLE moves to SWEEP.
  - op is latched into op_q; vector counter = 0; ones accumulator = 0.
  - Sweep takes priority: any in_valid that cycle is not accepted (in_ready=0).
- SWEEP:
  - in_ready = 0; sweep_busy = 1.
  - Each cycle with stage_free, load counter value as the vector with out_c = f(op_q, vec).
  - Then increment the counter and add out_c to the ones accumulator.
  - The vector with value 2^WIDTH-1 loads with out_last=1; the FSM then goes to DONE.
  - Back-pressure stalls the counter; no vector is skipped or duplicated.
  - sweep_start during SWEEP is ignored.
- DONE (one cycle):
  - sweep_ones <= accumulator (includes the final result); sweep_busy = 0; go to IDLE.
  - sweep_ones holds until the next sweep completes or reset.
  - The last result may still be waiting in the output stage.
- Counter wrap: CNT_W bits, so 2^WIDTH is representable. Terminal detection uses vec == 2^WIDTH-1, not overflow.
- Reserved op (6/7): out_c=0, out_err=1. In a sweep, the accumulator adds 0 for these.
- Reset mid-sweep: everything returns to reset values immediately; a partial accumulator is never published.
- Without back-pressure, a sweep produces 2^WIDTH results on consecutive cycles.

Decomposition:
- Shared package gate_pkg:
  - op_e enum (OP_AND..OP_XNOR, OP_RSV6, OP_RSV7).
  - sweep_state_e (IDLE, SWEEP, DONE).
  - Function gate_eval(op, vec) returning {err, c}, used by RTL and the bench model.
- One sub-module is natural: gate_out_stage, the valid/ready output register parametrised by payload width.

Test Plan:
- WIDTH=2, stream op=AND, out_ready=1, in_data 00,01,10,11 on consecutive cycles -> out_c 0,0,0,1, each 1 cycle after transfer; out_last=0.
- WIDTH=2, stream op=XOR, out_ready held low 3 cycles after first transfer of 10 -> out_vec=10/out_c=1 stable and in_ready=0 while stalled; resumes on out_ready=1.
- WIDTH=3, sweep_start with op=NAND, out_ready=1 -> 8 results vec 0..7 on consecutive cycles, out_c=1 except vec=7; out_last only on vec=7; sweep_ones=7; sweep_busy low after DONE.
- WIDTH=4, sweep op=XOR with random out_ready -> all 16 vectors appear exactly once in order; sweep_ones=8.
- sweep_start and in_valid asserted together in IDLE -> stream word not accepted; sweep begins at vec=0; sweep_start pulsed again mid-sweep is ignored.
- op=6 stream transfer -> out_err=1, out_c=0. Separately, rst_n low at vec=5 of a WIDTH=3 sweep -> all outputs 0 asynchronously, sweep_ones=0, FSM IDLE.

Source files
------------

// File: rtl/logic_gate_unit_pkg.sv
// ============================================================================
// Module : gate_pkg
// Shared gate-select / sweep-state types and the gate evaluation function.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package gate_pkg;

  localparam int MAX_W = 8;

  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_RSV6, OP_RSV7
  } op_e;

  typedef enum logic [1:0] {
    IDLE, SWEEP, DONE
  } sweep_state_e;

  // Returns {err, c}; only the low n bits of vec take part in the reduction.
  function automatic logic [1:0] gate_eval(op_e op, logic [MAX_W-1:0] vec, int n);
    logic       r_and;
    logic       r_or;
    logic       r_xor;
    logic [1:0] res;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  res = {1'b0, r_and};
      OP_OR:   res = {1'b0, r_or};
      OP_XOR:  res = {1'b0, r_xor};
      OP_NAND: res = {1'b0, ~r_and};
      OP_NOR:  res = {1'b0, ~r_or};
      OP_XNOR: res = {1'b0, ~r_xor};
      default: res = 2'b10;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_gate_unit_if.sv
// ============================================================================
// Module : logic_gate_unit_if
// Stream, sweep-control and result bundle of the logic gate unit.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface logic_gate_unit_if #(
  parameter int WIDTH = 2
);
  localparam int CNT_W = WIDTH + 1;

  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sweep_start;
  logic             sweep_busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic             out_c;
  logic             out_err;
  logic             out_last;
  logic [CNT_W-1:0] sweep_ones;

  modport master (
    output op, in_valid, in_data, sweep_start, out_ready,
    input  in_ready, sweep_busy, out_valid, out_vec, out_c, out_err,
           out_last, sweep_ones
  );

  modport slave (
    input  op, in_valid, in_data, sweep_start, out_ready,
    output in_ready, sweep_busy, out_valid, out_vec, out_c, out_err,
           out_last, sweep_ones
  );
endinterface

`default_nettype wire

// File: rtl/logic_gate_unit_out_stage.sv
// ============================================================================
// Module : gate_out_stage
// Single-entry valid/ready output register holding an opaque payload.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gate_out_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 out_ready_i,
  output logic                 stage_free_o,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;

  // The caller only asserts load_i while stage_free_o is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
    end else if (out_ready_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign stage_free_o = !valid_q || out_ready_i;
  assign valid_o      = valid_q;
  assign payload_o    = payload_q;

endmodule

`default_nettype wire

// File: rtl/logic_gate_unit.sv
// ============================================================================
// Module : logic_gate_unit
// Selectable WIDTH-input reduction gate with stream mode and truth-table sweep.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module logic_gate_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  logic_gate_unit_if.slave     gif
);

  localparam int CNT_W = WIDTH + 1;
  localparam int PAY_W = WIDTH + 3;

  sweep_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  op_e              op_q, op_d;

  logic             stage_free;
  logic             load;
  logic             in_ready;
  logic             last;
  logic [1:0]       eval;
  logic [PAY_W-1:0] pay_d;
  logic [PAY_W-1:0] pay_q;
  logic             terminal;

  assign terminal = (cnt_q[WIDTH-1:0] == {WIDTH{1'b1}});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ones_d   = ones_q;
    op_d     = op_q;
    in_ready = 1'b0;
    load     = 1'b0;
    last     = 1'b0;
    eval     = 2'b00;
    pay_d    = '0;
    case (state_q)
      IDLE: begin
        in_ready = stage_free && !gif.sweep_start;
        if (gif.sweep_start) begin
          state_d = SWEEP;
          op_d    = op_e'(gif.op);
          cnt_d   = '0;
          acc_d   = '0;
        end else if (gif.in_valid && in_ready) begin
          eval  = gate_eval(op_e'(gif.op), MAX_W'(gif.in_data), WIDTH);
          load  = 1'b1;
          pay_d = {gif.in_data, eval[0], eval[1], 1'b0};
        end
      end
      SWEEP: begin
        // The counter only advances when its value actually enters the stage.
        if (stage_free) begin
          eval  = gate_eval(op_q, MAX_W'(cnt_q[WIDTH-1:0]), WIDTH);
          last  = terminal;
          load  = 1'b1;
          pay_d = {cnt_q[WIDTH-1:0], eval[0], eval[1], last};
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = acc_q + CNT_W'(eval[0]);
          if (terminal) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ones_d  = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      op_q    <= OP_AND;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      op_q    <= op_d;
    end
  end

  gate_out_stage #(
    .PAYLOAD_W (PAY_W)
  ) u_out_stage (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .payload_i    (pay_d),
    .out_ready_i  (gif.out_ready),
    .stage_free_o (stage_free),
    .valid_o      (gif.out_valid),
    .payload_o    (pay_q)
  );

  assign gif.in_ready   = in_ready;
  assign gif.sweep_busy = (state_q == SWEEP);
  assign gif.sweep_ones = ones_q;
  assign gif.out_vec    = pay_q[PAY_W-1:3];
  assign gif.out_c      = pay_q[2];
  assign gif.out_err    = pay_q[1];
  assign gif.out_last   = pay_q[0];

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
// ============================================================================
// Module : tb_logic_gate_unit
// Self-checking bench for logic_gate_unit at WIDTH 2, 3 and 4.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_gate_unit_if #(.WIDTH(2)) if2 ();
  logic_gate_unit_if #(.WIDTH(3)) if3 ();
  logic_gate_unit_if #(.WIDTH(4)) if4 ();

  logic_gate_unit #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .gif(if2.slave));
  logic_gate_unit #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .gif(if3.slave));
  logic_gate_unit #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .gif(if4.slave));

  int total = 0;
  int bad   = 0;

  // Truth-table reference written directly from the gate definitions.
  function automatic bit ref_c(int op, int v, int w);
    int all_ones = (1 << w) - 1;
    case (op)
      0: return v == all_ones;
      1: return v != 0;
      2: return ($countones(v) % 2) == 1;
      3: return v != all_ones;
      4: return v == 0;
      5: return ($countones(v) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_ones(int op, int w);
    int n = 0;
    for (int v = 0; v < (1 << w); v++) n += int'(ref_c(op, v, w));
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if2.op = 3'd0; if2.in_valid = 1'b0; if2.in_data = '0; if2.sweep_start = 1'b0; if2.out_ready = 1'b1;
    if3.op = 3'd0; if3.in_valid = 1'b0; if3.in_data = '0; if3.sweep_start = 1'b0; if3.out_ready = 1'b1;
    if4.op = 3'd0; if4.in_valid = 1'b0; if4.in_data = '0; if4.sweep_start = 1'b0; if4.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++; if ({if2.out_valid, if2.out_c, if2.out_err, if2.out_last, if2.sweep_busy} !== 5'b0) begin
      bad++; $display("FAIL reset_flags w2 got=%b want=00000", {if2.out_valid, if2.out_c, if2.out_err, if2.out_last, if2.sweep_busy}); end
    total++; if (if2.out_vec !== 2'b00) begin bad++; $display("FAIL reset_vec got=%b want=00", if2.out_vec); end
    total++; if (if3.sweep_ones !== 4'd0) begin bad++; $display("FAIL reset_ones got=%0d want=0", if3.sweep_ones); end
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_w4 got=%b want=0", if4.out_valid); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream_and();
    if2.op = 3'd0; if2.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      if2.in_valid = 1'b1; if2.in_data = 2'(v);
      #1;
      total++; if (if2.in_ready !== 1'b1) begin bad++; $display("FAIL and_in_ready v=%0d got=%b want=1", v, if2.in_ready); end
      tick();
      total++; if ({if2.out_valid, if2.out_vec, if2.out_c, if2.out_last} !== {1'b1, 2'(v), ref_c(0, v, 2), 1'b0}) begin
        bad++; $display("FAIL and_result v=%0d got=%b want=%b", v, {if2.out_valid, if2.out_vec, if2.out_c, if2.out_last},
                        {1'b1, 2'(v), ref_c(0, v, 2), 1'b0}); end
    end
    if2.in_valid = 1'b0;
    tick();
    total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL and_drain got=%b want=0", if2.out_valid); end
  endtask

  task automatic test_stall_xor();
    if2.op = 3'd2; if2.out_ready = 1'b1; if2.in_valid = 1'b1; if2.in_data = 2'b10;
    tick();
    if2.out_ready = 1'b0; if2.in_data = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if ({if2.out_valid, if2.out_vec, if2.out_c, if2.in_ready} !== 5'b1_10_1_0) begin
        bad++; $display("FAIL stall_hold k=%0d got=%b want=11010", k, {if2.out_valid, if2.out_vec, if2.out_c, if2.in_ready}); end
      tick();
    end
    if2.out_ready = 1'b1;
    #1;
    total++; if (if2.in_ready !== 1'b1) begin bad++; $display("FAIL stall_resume_ready got=%b want=1", if2.in_ready); end
    tick();
    if2.in_valid = 1'b0;
    total++; if ({if2.out_valid, if2.out_vec, if2.out_c} !== 4'b1_01_1) begin
      bad++; $display("FAIL stall_next got=%b want=1011", {if2.out_valid, if2.out_vec, if2.out_c}); end
    tick();
  endtask

  task automatic test_reserved();
    for (int op = 6; op < 8; op++) begin
      if2.op = 3'(op); if2.in_valid = 1'b1; if2.in_data = 2'b11; if2.out_ready = 1'b1;
      tick();
      total++; if ({if2.out_valid, if2.out_err, if2.out_c} !== 3'b110) begin
        bad++; $display("FAIL reserved op=%0d got=%b want=110", op, {if2.out_valid, if2.out_err, if2.out_c}); end
    end
    if2.in_valid = 1'b0; if2.op = 3'd0;
    tick();
  endtask

  task automatic test_random_stream();
    bit       exp_valid = 1'b0;
    bit [3:0] exp_vec = '0;
    bit       exp_c = 1'b0;
    bit       exp_err = 1'b0;
    for (int k = 0; k < 80; k++) begin
      bit iv  = 1'($urandom_range(0, 1));
      bit rdy = 1'($urandom_range(0, 3) != 0);
      int d   = int'($urandom_range(0, 15));
      int op  = int'($urandom_range(0, 7));
      bit acc;
      if4.in_valid = iv; if4.in_data = 4'(d); if4.op = 3'(op); if4.out_ready = rdy;
      #1;
      total++; if (if4.in_ready !== (!exp_valid || rdy)) begin
        bad++; $display("FAIL rnd_in_ready k=%0d got=%b want=%b", k, if4.in_ready, !exp_valid || rdy); end
      acc = iv && (!exp_valid || rdy);
      tick();
      if (acc) begin
        exp_valid = 1'b1; exp_vec = 4'(d); exp_c = ref_c(op, d, 4); exp_err = (op >= 6);
      end else if (rdy) begin
        exp_valid = 1'b0;
      end
      total++; if (if4.out_valid !== exp_valid) begin
        bad++; $display("FAIL rnd_valid k=%0d got=%b want=%b", k, if4.out_valid, exp_valid); end
      if (exp_valid) begin
        total++; if ({if4.out_vec, if4.out_c, if4.out_err, if4.out_last} !== {exp_vec, exp_c, exp_err, 1'b0}) begin
          bad++; $display("FAIL rnd_payload k=%0d got=%b want=%b", k, {if4.out_vec, if4.out_c, if4.out_err, if4.out_last},
                          {exp_vec, exp_c, exp_err, 1'b0}); end
      end
    end
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_sweep_nand();
    int waited = 0;
    if3.op = 3'd3; if3.out_ready = 1'b1; if3.sweep_start = 1'b1;
    tick();
    if3.sweep_start = 1'b0; if3.op = 3'd0;
    while (!if3.out_valid && waited < 5) begin tick(); waited++; end
    total++; if (if3.out_valid !== 1'b1) begin bad++; $display("FAIL nand_start_timeout got=%b want=1", if3.out_valid); end
    for (int v = 0; v < 8; v++) begin
      total++; if ({if3.out_valid, if3.out_vec, if3.out_c, if3.out_last} !== {1'b1, 3'(v), ref_c(3, v, 3), v == 7}) begin
        bad++; $display("FAIL nand_result v=%0d got=%b want=%b", v, {if3.out_valid, if3.out_vec, if3.out_c, if3.out_last},
                        {1'b1, 3'(v), ref_c(3, v, 3), v == 7}); end
      if (v < 7) begin
        total++; if (if3.sweep_busy !== 1'b1) begin bad++; $display("FAIL nand_busy v=%0d got=%b want=1", v, if3.sweep_busy); end
      end
      tick();
    end
    total++; if ({if3.sweep_busy, if3.sweep_ones} !== {1'b0, 4'(ref_ones(3, 3))}) begin
      bad++; $display("FAIL nand_done got=%b/%0d want=0/%0d", if3.sweep_busy, if3.sweep_ones, ref_ones(3, 3)); end
  endtask

  task automatic test_sweep_random_ready();
    int  got = 0;
    bit  held = 1'b0;
    logic [3:0] held_vec = '0;
    if4.op = 3'd2; if4.sweep_start = 1'b1;
    tick();
    if4.sweep_start = 1'b0; if4.op = 3'd1;
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      bit rdy = 1'($urandom_range(0, 1));
      if4.out_ready = rdy;
      if (if4.out_valid) begin
        if (held) begin
          total++; if (if4.out_vec !== held_vec) begin
            bad++; $display("FAIL xsweep_hold got=%0d want=%0d", if4.out_vec, held_vec); end
        end
        if (rdy) begin
          total++; if ({if4.out_vec, if4.out_c, if4.out_last} !== {4'(got), ref_c(2, got, 4), got == 15}) begin
            bad++; $display("FAIL xsweep_result n=%0d got=%b want=%b", got, {if4.out_vec, if4.out_c, if4.out_last},
                            {4'(got), ref_c(2, got, 4), got == 15}); end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1; held_vec = if4.out_vec;
        end
      end
      tick();
    end
    total++; if (got != 16) begin bad++; $display("FAIL xsweep_count got=%0d want=16", got); end
    if4.out_ready = 1'b1;
    tick();
    total++; if ({if4.sweep_busy, if4.sweep_ones} !== {1'b0, 5'(ref_ones(2, 4))}) begin
      bad++; $display("FAIL xsweep_ones got=%b/%0d want=0/%0d", if4.sweep_busy, if4.sweep_ones, ref_ones(2, 4)); end
  endtask

  task automatic test_collision();
    if3.op = 3'd1; if3.out_ready = 1'b1; if3.sweep_start = 1'b1; if3.in_valid = 1'b1; if3.in_data = 3'b101;
    #1;
    total++; if (if3.in_ready !== 1'b0) begin bad++; $display("FAIL coll_in_ready got=%b want=0", if3.in_ready); end
    tick();
    if3.sweep_start = 1'b0; if3.in_valid = 1'b0;
    total++; if ({if3.sweep_busy, if3.out_valid} !== 2'b10) begin
      bad++; $display("FAIL coll_start got=%b want=10", {if3.sweep_busy, if3.out_valid}); end
    for (int v = 0; v < 8; v++) begin
      tick();
      if (v == 4) begin if3.sweep_start = 1'b0; if3.op = 3'd1; end
      total++; if ({if3.out_valid, if3.out_vec, if3.out_c, if3.out_last} !== {1'b1, 3'(v), ref_c(1, v, 3), v == 7}) begin
        bad++; $display("FAIL coll_result v=%0d got=%b want=%b", v, {if3.out_valid, if3.out_vec, if3.out_c, if3.out_last},
                        {1'b1, 3'(v), ref_c(1, v, 3), v == 7}); end
      if (v == 3) begin if3.sweep_start = 1'b1; if3.op = 3'd3; end
    end
    tick();
    total++; if ({if3.out_valid, if3.sweep_busy, if3.sweep_ones} !== {2'b00, 4'(ref_ones(1, 3))}) begin
      bad++; $display("FAIL coll_end got=%b/%b/%0d want=0/0/%0d", if3.out_valid, if3.sweep_busy, if3.sweep_ones, ref_ones(1, 3)); end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    if3.op = 3'd3; if3.out_ready = 1'b1; if3.sweep_start = 1'b1;
    tick();
    if3.sweep_start = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (if3.out_valid && if3.out_vec == 3'd5) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_vec5 got=0 want=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({if3.out_valid, if3.out_vec, if3.out_c, if3.out_err, if3.out_last, if3.sweep_busy} !== 8'b0) begin
      bad++; $display("FAIL rst_async got=%b want=00000000",
                      {if3.out_valid, if3.out_vec, if3.out_c, if3.out_err, if3.out_last, if3.sweep_busy}); end
    total++; if (if3.sweep_ones !== 4'd0) begin bad++; $display("FAIL rst_ones got=%0d want=0", if3.sweep_ones); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL rst_idle_ready got=%b want=1", if3.in_ready); end
    tick();
    total++; if ({if3.sweep_busy, if3.out_valid, if3.sweep_ones} !== 6'b0) begin
      bad++; $display("FAIL rst_after got=%b/%b/%0d want=0/0/0", if3.sweep_busy, if3.out_valid, if3.sweep_ones); end
  endtask

  initial begin
    test_reset();
    test_stream_and();
    test_stall_xor();
    test_reserved();
    test_random_stream();
    test_sweep_nand();
    test_sweep_random_ready();
    test_collision();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
